// File: rtl/sipo_frame_rx.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx
//
// Purpose:
//   Serial-to-parallel frame receiver. Consumes a serial bit stream, one bit per
//   EN strobe. A '1' seen in IDLE is the start bit. The next WIDTH strobed bits
//   are data, LSB first. The completed word is presented on a valid/ready
//   interface. If a new word completes while the previous one is still
//   unconsumed, the new word is dropped and a sticky overrun flag is set.
//
// Optional feature (macro SIPO_FRAME_RX_PARITY_EN):
//   When the macro is defined, each frame carries one even-parity bit after the
//   data bits. PERR is loaded with ^word ^ parity_bit together with Q. When the
//   macro is undefined there is no PAR state and PERR is tied to 0.
//
// Parameters:
//   WIDTH : data bits per frame (2..32)
//   CNT_W : bit-counter width, 2**CNT_W > WIDTH
//
// Ports:
//   C    in   clock, rising edge
//   R    in   asynchronous active-low reset
//   D    in   serial data in
//   EN   in   bit strobe; D is sampled only on edges with EN=1
//   Q    out  received word, LSB = first data bit received
//   VLD  out  Q holds an unconsumed word
//   RDY  in   consumer accepts Q when VLD=1 and RDY=1
//   OVF  out  sticky overrun flag, cleared only by reset
//   PERR out  parity error on the word in Q (0 without the feature)
//   BUSY out  a frame is being collected
// -----------------------------------------------------------------------------
module sipo_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             VLD,
    input  logic             RDY,
    output logic             OVF,
    output logic             PERR,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Even parity: result is 1 when the word plus its parity bit hold an odd
    // number of ones.
    function automatic logic even_par_err(input logic [WIDTH-1:0] word,
                                          input logic             pbit);
        return (^word) ^ pbit;
    endfunction
`endif

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   r_q;
    logic               r_vld;
    logic               r_ovf;
    logic               r_busy;
    logic               w_done;
    logic [WIDTH-1:0]   w_word;
    logic               w_load;
    logic               w_drop;

    // Next-state decode and frame-completion detection.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_word       = {D, r_sreg[WIDTH-1:1]};
        case (r_state)
            ST_IDLE: begin
                if (EN && D) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (EN && (r_cnt == CNT_LAST)) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                    w_next_state = ST_PAR;
`else
                    w_next_state = ST_IDLE;
                    w_done       = 1'b1;
`endif
                end else begin
                    w_next_state = ST_DATA;
                end
            end
`ifdef SIPO_FRAME_RX_PARITY_EN
            ST_PAR: begin
                // The completed word already sits in r_sreg; D is the parity bit.
                if (EN) begin
                    w_next_state = ST_IDLE;
                    w_done       = 1'b1;
                    w_word       = r_sreg;
                end else begin
                    w_next_state = ST_PAR;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A completed word loads unless the previous word is still held and not
    // being accepted on this same edge; in that case it is dropped.
    assign w_load = w_done && (!r_vld || RDY);
    assign w_drop = w_done && r_vld && !RDY;

    // State register; BUSY is registered from the next state so it tracks state.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    // Bit counter and shift register; both only move on strobed edges.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_cnt  <= CNT_ZERO;
            r_sreg <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (EN && D) begin
                        r_cnt <= CNT_ZERO;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_DATA: begin
                    if (EN) begin
                        r_sreg <= {D, r_sreg[WIDTH-1:1]};
                        r_cnt  <= r_cnt + CNT_ONE;
                    end else begin
                        r_sreg <= r_sreg;
                    end
                end
                default: begin
                    r_cnt  <= r_cnt;
                    r_sreg <= r_sreg;
                end
            endcase
        end
    end

    // Output word register, valid flag and sticky overrun.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_q   <= '0;
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_load) begin
                r_q   <= w_word;
                r_vld <= 1'b1;
            end else if (r_vld && RDY) begin
                r_vld <= 1'b0;
            end else begin
                r_vld <= r_vld;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic r_perr;

    // Parity status travels with Q: it changes only when Q is loaded.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= even_par_err(w_word, D);
        end else begin
            r_perr <= r_perr;
        end
    end

    assign PERR = r_perr;
`else
    assign PERR = 1'b0;
`endif

    assign Q    = r_q;
    assign VLD  = r_vld;
    assign OVF  = r_ovf;
    assign BUSY = r_busy;

endmodule
